// File: rtl/dual_ram_arb_pkg.sv
// dual_ram_arb_pkg: shared types and the round-robin pick helper for dual_ram_arbiter
package dual_ram_arb_pkg;
  localparam int MAX_REQ = 32;
  localparam int IDX_W = $clog2(MAX_REQ);
  typedef struct packed {
    logic found;
    logic [MAX_REQ-1:0] grant;
    logic [IDX_W-1:0] idx;
  } pick_t;
  // Scans downward so the last hit written is the closest one at or after ptr.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input int n, input int ptr);
    pick_t p;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--)
      if (k < n) begin
        int j;
        j = (ptr + k) % n;
        if (req[j]) begin
          p.found = 1'b1;
          p.idx = j[IDX_W-1:0];
          p.grant = MAX_REQ'(1) << j;
        end
      end
    return p;
  endfunction
endpackage

// File: rtl/dual_ram_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant with a pointer that advances past the last winner
module rr_arbiter
  import dual_ram_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [ID_W-1:0] idx
);
  logic [ID_W-1:0] ptr;
  pick_t p;
  assign p = rr_pick(MAX_REQ'(req), N, int'(ptr));
  assign grant = N'(p.grant);
  assign idx = ID_W'(p.idx);
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (p.found) ptr <= (idx == ID_W'(N - 1)) ? '0 : idx + ID_W'(1);
endmodule

// File: rtl/dual_ram_arbiter.sv
// dual_ram_arbiter: independent round-robin write/read arbitration onto one dual_ram.
// Define DUAL_RAM_ARB_FWD_EN to forward same-address write data to a colliding read.
module dual_ram_arbiter
  import dual_ram_arb_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int RAM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic clk,
  input  logic rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_we,
  input  logic [N_REQ*ADDR_SIZE-1:0] req_addr,
  input  logic [N_REQ*RAM_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0] req_ready,
  output logic rsp_valid,
  output logic [ID_W-1:0] rsp_id,
  output logic [RAM_WIDTH-1:0] rsp_data,
  output logic ram_wr_enb,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic ram_rd_enb,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [RAM_WIDTH-1:0] ram_data_out
);
  if (N_REQ < 2 || N_REQ > MAX_REQ || longint'(RAM_DEPTH) > (longint'(1) << ADDR_SIZE)) begin : g_bad_cfg
    $error("dual_ram_arbiter: unsupported N_REQ/RAM_DEPTH/ADDR_SIZE");
  end
  logic [N_REQ-1:0] wr_req, rd_req, wr_gnt, rd_gnt;
  logic [ID_W-1:0] wr_idx, rd_idx, rd_id_s1;
  assign wr_req = rst ? '0 : req_valid & req_we;
  assign rd_req = rst ? '0 : req_valid & ~req_we;
  assign req_ready = wr_gnt | rd_gnt;
  rr_arbiter #(.N(N_REQ)) u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .grant(wr_gnt), .idx(wr_idx));
  rr_arbiter #(.N(N_REQ)) u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .grant(rd_gnt), .idx(rd_idx));
  always_ff @(posedge clk)
    if (rst) begin
      ram_wr_enb <= 1'b0;
      ram_wr_addr <= '0;
      ram_data_in <= '0;
      ram_rd_enb <= 1'b0;
      ram_rd_addr <= '0;
      rd_id_s1 <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
    end else begin
      ram_wr_enb <= |wr_gnt;
      ram_rd_enb <= |rd_gnt;
      rsp_valid <= ram_rd_enb;
      rsp_id <= rd_id_s1;
      if (|wr_gnt) begin
        ram_wr_addr <= req_addr[int'(wr_idx)*ADDR_SIZE +: ADDR_SIZE];
        ram_data_in <= req_wdata[int'(wr_idx)*RAM_WIDTH +: RAM_WIDTH];
      end
      if (|rd_gnt) begin
        ram_rd_addr <= req_addr[int'(rd_idx)*ADDR_SIZE +: ADDR_SIZE];
        rd_id_s1 <= rd_idx;
      end
    end
`ifdef DUAL_RAM_ARB_FWD_EN
  logic fwd_hit;
  logic [RAM_WIDTH-1:0] fwd_data;
  always_ff @(posedge clk)
    if (rst) begin
      fwd_hit <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit <= ram_wr_enb && ram_rd_enb && ram_wr_addr == ram_rd_addr;
      fwd_data <= ram_data_in;
    end
  assign rsp_data = !rsp_valid ? '0 : fwd_hit ? fwd_data : ram_data_out;
`else
  assign rsp_data = rsp_valid ? ram_data_out : '0;
`endif
endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb_dual_ram_arbiter: scoreboard bench with a behavioural RAM and a spec-level arbitration model
module tb_dual_ram_arbiter;
  localparam int N = 4, W = 8, A = 8;
`ifdef DUAL_RAM_ARB_FWD_EN
  localparam int COL_EXP = 'h5A;
`else
  localparam int COL_EXP = 'h11;
`endif
  typedef struct { int id; int data; int due; } rsp_t;
  typedef struct { int addr; int data; int due; } cmd_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_we = '0, req_ready;
  logic [N*A-1:0] req_addr = '0;
  logic [N*W-1:0] req_wdata = '0;
  logic rsp_valid, ram_wr_enb, ram_rd_enb;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_data, ram_data_in, ram_data_out;
  logic [A-1:0] ram_wr_addr, ram_rd_addr;
  logic [W-1:0] mem [256] = '{default: '0};
  int shadow [256] = '{default: 0};
  rsp_t rsp_q[$];
  cmd_t wq[$], rq[$];
  int wr_order[$], rd_order[$];
  int checks = 0, failures = 0, cyc = 0, wp = 0, rp = 0, last_rsp = -1;
  logic [N-1:0] hs = '0;

  always #5 clk = ~clk;

  dual_ram_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr),
    .ram_data_in(ram_data_in), .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr),
    .ram_data_out(ram_data_out)
  );

  always @(posedge clk) begin
    if (ram_wr_enb) mem[ram_wr_addr] <= ram_data_in;
    if (rst) ram_data_out <= '0;
    else if (ram_rd_enb) ram_data_out <= mem[ram_rd_addr];
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    rsp_t e;
    cmd_t c;
    int w, r, ra, wa, d;
    logic [N-1:0] exp_rdy;
    if (rsp_valid) last_rsp = int'(rsp_data);
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      e = rsp_q.pop_front();
      check("rsp_valid", int'(rsp_valid), 1);
      check("rsp_id", int'(rsp_id), e.id);
      check("rsp_data", int'(rsp_data), e.data);
    end else check("rsp_spurious", int'(rsp_valid), 0);
    if (wq.size() > 0 && wq[0].due == cyc) begin
      c = wq.pop_front();
      check("ram_wr_enb", int'(ram_wr_enb), 1);
      check("ram_wr_addr", int'(ram_wr_addr), c.addr);
      check("ram_data_in", int'(ram_data_in), c.data);
    end else check("ram_wr_enb_idle", int'(ram_wr_enb), 0);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      c = rq.pop_front();
      check("ram_rd_enb", int'(ram_rd_enb), 1);
      check("ram_rd_addr", int'(ram_rd_addr), c.addr);
    end else check("ram_rd_enb_idle", int'(ram_rd_enb), 0);
    if (rst) begin
      wp = 0;
      rp = 0;
      rsp_q.delete();
      hs = '0;
      check("ready_in_reset", int'(req_ready), 0);
    end else begin
      w = pick(req_valid & req_we, wp);
      r = pick(req_valid & ~req_we, rp);
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      if (r >= 0) exp_rdy[r] = 1'b1;
      check("req_ready", int'(req_ready), int'(exp_rdy));
      hs = exp_rdy;
      if (r >= 0) begin
        ra = int'(req_addr[r*A +: A]);
        d = shadow[ra];
`ifdef DUAL_RAM_ARB_FWD_EN
        if (w >= 0 && int'(req_addr[w*A +: A]) == ra) d = int'(req_wdata[w*W +: W]);
`endif
        rsp_q.push_back('{r, d, cyc + 2});
        rq.push_back('{ra, 0, cyc + 1});
        rd_order.push_back(r);
        rp = (r + 1) % N;
      end
      if (w >= 0) begin
        wa = int'(req_addr[w*A +: A]);
        d = int'(req_wdata[w*W +: W]);
        wq.push_back('{wa, d, cyc + 1});
        shadow[wa] = d;
        wr_order.push_back(w);
        wp = (w + 1) % N;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic we, input int a, input int d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*A +: A] = A'(a);
    req_wdata[i*W +: W] = W'(d);
  endtask

  task automatic drain();
    int n = 0;
    while (req_valid != '0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_timeout", int'(n < 50), 1);
    repeat (4) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_wr_enb", int'(ram_wr_enb), 0);
    check("rst_wr_addr", int'(ram_wr_addr), 0);
    check("rst_data_in", int'(ram_data_in), 0);
    check("rst_rd_enb", int'(ram_rd_enb), 0);
    check("rst_rd_addr", int'(ram_rd_addr), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_data", int'(rsp_data), 0);
    tick();
    rst = 1'b0;
    issue(2, 1'b0, 'h10, 0);
    drain();
    check("first_read", last_rsp, 0);
    wr_order.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) issue(i, 1'b1, 'h80 + i, int'($urandom_range(255)));
      tick();
    end
    drain();
    check("wr_order_len", int'(wr_order.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      if (k < wr_order.size()) check($sformatf("wr_order_%0d", k), wr_order[k], k % 4);
    issue(1, 1'b1, 'h20, 'hA5);
    issue(3, 1'b0, 'h30, 0);
    tick();
    check("par_both_granted", int'(hs), 'b1010);
    issue(0, 1'b0, 'h20, 0);
    tick();
    drain();
    check("par_readback", last_rsp, 'hA5);
    issue(0, 1'b1, 'h40, 'h11);
    tick();
    drain();
    issue(0, 1'b1, 'h40, 'h5A);
    issue(1, 1'b0, 'h40, 0);
    tick();
    check("col_both_granted", int'(hs), 'b0011);
    drain();
    check("col_data", last_rsp, COL_EXP);
    issue(2, 1'b0, 'h10, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_drop", int'(rsp_valid), 0);
    tick();
    issue(0, 1'b1, 'h50, 1);
    issue(2, 1'b1, 'h52, 2);
    issue(1, 1'b0, 'h60, 0);
    issue(3, 1'b0, 'h62, 0);
    tick();
    check("ptr_reset_grant", int'(hs), 'b0011);
    drain();
    issue(2, 1'b0, 'h10, 0);
    tick();
    drain();
    rd_order.delete();
    for (int c = 0; c < 6; c++) begin
      if (!req_valid[3]) issue(3, 1'b0, int'($urandom_range(255)), 0);
      if (!req_valid[0]) issue(0, 1'b0, int'($urandom_range(255)), 0);
      tick();
    end
    drain();
    check("wrap_len", int'(rd_order.size() >= 3), 1);
    for (int k = 0; k < 3; k++)
      if (k < rd_order.size()) check($sformatf("wrap_order_%0d", k), rd_order[k], (k % 2 == 0) ? 3 : 0);
    rd_order.delete();
    for (int c = 0; c < 4; c++) begin
      if (!req_valid[1]) issue(1, 1'b0, int'($urandom_range(255)), 0);
      tick();
    end
    check("lone_grants", rd_order.size(), 4);
    drain();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) rst = 1'b1;
      if (c == 202) rst = 1'b0;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(1) == 1)
          issue(i, 1'($urandom_range(1)), 'h40 + int'($urandom_range(7)), int'($urandom_range(255)));
      tick();
    end
    drain();
    check("scoreboard_empty", rsp_q.size() + wq.size() + rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
